fft_bfly_stage: RTL
===================

# fft_bfly_stage

Parametrised, streaming radix-2 DIT butterfly stage for the FFT datapath. It generalises the fixed 16-point, 17-bit butterfly stages to any power-of-two size N, stage index, data width and twiddle width. It processes one butterfly (a, b) per accepted beat and drives the address of an external synchronous twiddle ROM. It adds a valid/ready handshake with backpressure, per-stage ÷2 scaling, rounding, saturation, a sticky overflow flag and end-of-frame marking.

## Interface
- DW, 17: signed data width per real/imag component.
- TW, 8: signed twiddle width; 1.0 = 2^(TW-2) (64 for TW=8).
- LOG2N, 4: log2 of FFT size N.
- STAGE, 0: stage index, 0..LOG2N-1.

- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_a_re, in_a_im, in_b_re, in_b_im  in  DW each  butterfly operands, signed.
- tw_addr  out  LOG2N-1  twiddle ROM address for the beat currently offered.
- tw_en  out  1  ROM read enable; ROM registers tw_re/tw_im on edges where tw_en=1.
- tw_re, tw_im  in  TW each  ROM data, valid the cycle after the address is sampled.
- scale  in  1  1 = divide stage outputs by 2; sampled with the beat.
- clear_ovf  in  1  clears ovf.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- out_x0_re, out_x0_im, out_x1_re, out_x1_im  out  DW each  x0 = a + b·w and x1 = a − b·w.
- out_last  out  1  final butterfly (N/2−1) of a frame.
- ovf  out  1  sticky saturation flag.

## Operation
- stall = out_valid & ~out_ready. in_ready = ~stall & ~rst. tw_en = in_ready.
- accept = in_valid & in_ready. When stall=1, every pipeline register, the counter and the ROM output hold. Bubbles are not collapsed; one global enable drives the whole pipeline.
- Butterfly counter j (LOG2N−1 bits) increments on accept and wraps from N/2−1 to 0.
- tw_addr is combinational: tw_addr = (j mod 2^STAGE) << (LOG2N−1−STAGE). For STAGE=0 it is always 0.
- P1 (accept edge): registers a, b, scale, valid, last = (j == N/2−1). The ROM samples tw_addr on the same edge.
- P2: complex multiply by w = tw_re + j·tw_im.
  - p_re = b_re·tw_re − b_im·tw_im; p_im = b_re·tw_im + b_im·tw_re.
  - Full-precision products; then add 2^(TW−3) and arithmetic-shift right by TW−2 (round half up).
  - Result kept at DW+2 bits with no intermediate saturation.
- P3: form sum = a + p and diff = a − p at DW+3 bits.
  - If scale=1, add 1 and arithmetic-shift right by 1.
  - Saturate each component to [−2^(DW−1), 2^(DW−1)−1].
  - Any saturated component sets ovf.
- ovf is cleared by rst or clear_ovf. A set event in the same cycle as clear_ovf wins, so ovf=1.
- Output registers update only when the pipeline enable is 1 (i.e. no stall).

## Timing
- Latency: a beat accepted at edge E appears at out_valid after edge E+3 when there are no stalls. Each stall cycle adds one cycle.
- Throughput: one butterfly per cycle while out_ready=1.
- The output beat is held stable while out_valid=1 and out_ready=0, and is consumed on the edge where both are 1.
- Reset (rst=1 at an edge) is abortive: it clears all valid bits, j, ovf, out_last and all output data to 0, and discards in-flight beats. in_ready=0 during reset and 1 on the first cycle after.
- in_valid=0 with no stall inserts a bubble; j does not advance.

## Test plan
- Parameters DW=17, TW=8, LOG2N=4, scale=0. Beat a=(100,0), b=(50,0), w=(64,0) -> three cycles later x0=(150,0), x1=(50,0). The same beat with scale=1 -> x0=(75,0), x1=(25,0).
- w=(0,−64), a=(100,0), b=(50,0) -> x0=(100,−50), x1=(100,50).
- Rounding: w=(45,−45), a=(0,0), b=(100,0) -> p=(70,−70), x0=(70,−70), x1=(−70,70).
- Saturation: a=b=(65535,0), w=(64,0) -> x0=(65535,0), x1=(0,0), ovf=1. ovf stays 1 until clear_ovf, then reads 0.
- Address/framing: stream 16 back-to-back beats.
  - STAGE=3: tw_addr = 0..7, 0..7.
  - STAGE=1: tw_addr = 0,4,0,4,…
  - out_last is high on the 8th and 16th outputs.
- Backpressure and reset: out_ready=0 for 5 cycles mid-stream -> in_ready=0 and outputs stable, with no beat lost or duplicated after release. Then assert rst for 1 cycle with 3 beats in flight -> out_valid=0 on the next cycle, j restarts at 0, and tw_addr returns to 0.

Source files
------------

// File: rtl/fft_bfly_stage.sv
// Streaming radix-2 DIT butterfly stage: x0 = a + b*w, x1 = a - b*w.
// Four-deep pipeline (operand capture, complex multiply, add/sub with
// optional /2, saturate). A single global enable freezes everything,
// including the twiddle ROM read, while the output is backpressured.
module fft_bfly_stage #(
  parameter int DW    = 17,
  parameter int TW    = 8,
  parameter int LOG2N = 4,
  parameter int STAGE = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_a_re,
  input  logic signed [DW-1:0] in_a_im,
  input  logic signed [DW-1:0] in_b_re,
  input  logic signed [DW-1:0] in_b_im,
  output logic [LOG2N-2:0]     tw_addr,
  output logic                 tw_en,
  input  logic signed [TW-1:0] tw_re,
  input  logic signed [TW-1:0] tw_im,
  input  logic                 scale,
  input  logic                 clear_ovf,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] out_x0_re,
  output logic signed [DW-1:0] out_x0_im,
  output logic signed [DW-1:0] out_x1_re,
  output logic signed [DW-1:0] out_x1_im,
  output logic                 out_last,
  output logic                 ovf
);

  localparam int AW = LOG2N - 1;
  localparam int PW = DW + TW + 1;
  localparam int SW = DW + 3;
  localparam int SH = LOG2N - 1 - STAGE;
  localparam logic [AW-1:0]        MASK  = AW'((1 << STAGE) - 1);
  localparam logic signed [PW-1:0] HALF  = PW'(1) << (TW - 3);
  localparam logic signed [SW-1:0] ONE_S = SW'(1);

  // Round half up and drop the twiddle's fractional bits (1.0 = 2^(TW-2)).
  function automatic logic signed [DW+1:0] round_prod(input logic signed [PW-1:0] x);
    logic signed [PW-1:0] t;
    t = x + HALF;
    t = t >>> (TW - 2);
    return t[DW+1:0];
  endfunction

  // Optional divide-by-two with round half up.
  function automatic logic signed [SW-1:0] halve(input logic signed [SW-1:0] x,
                                                 input logic en_div);
    logic signed [SW-1:0] t;
    t = x + ONE_S;
    t = t >>> 1;
    return en_div ? t : x;
  endfunction

  // True when x does not fit in DW signed bits.
  function automatic logic sat_hit(input logic signed [SW-1:0] x);
    return !((&x[SW-1:DW-1]) || !(|x[SW-1:DW-1]));
  endfunction

  // Clamp to the DW-bit signed range.
  function automatic logic signed [DW-1:0] sat(input logic signed [SW-1:0] x);
    if (sat_hit(x))
      return x[SW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    return x[DW-1:0];
  endfunction

  logic          stall, en, accept;
  logic [AW-1:0] j;

  logic                 vld_p1, last_p1, scale_p1;
  logic signed [DW-1:0] a_re_p1, a_im_p1, b_re_p1, b_im_p1;
  logic                 vld_p2, last_p2, scale_p2;
  logic signed [DW-1:0] a_re_p2, a_im_p2;
  logic signed [DW+1:0] p_re_p2, p_im_p2;
  logic                 vld_p3, last_p3;
  logic signed [SW-1:0] s_re_p3, s_im_p3, d_re_p3, d_im_p3;

  logic signed [PW-1:0] mul_re, mul_im;
  logic signed [SW-1:0] sum_re, sum_im, dif_re, dif_im;
  logic                 ovf_set;

  assign stall    = out_valid & ~out_ready;
  assign en       = ~stall;
  assign in_ready = ~stall & ~rst;
  assign tw_en    = in_ready;
  assign accept   = in_valid & in_ready;
  assign tw_addr  = (j & MASK) << SH;

  // Complex product b*w at full precision
  always_comb begin
    mul_re = PW'(b_re_p1) * PW'(tw_re) - PW'(b_im_p1) * PW'(tw_im);
    mul_im = PW'(b_re_p1) * PW'(tw_im) + PW'(b_im_p1) * PW'(tw_re);
  end

  // Butterfly sum and difference, wide enough to never wrap
  always_comb begin
    sum_re = SW'(a_re_p2) + SW'(p_re_p2);
    sum_im = SW'(a_im_p2) + SW'(p_im_p2);
    dif_re = SW'(a_re_p2) - SW'(p_re_p2);
    dif_im = SW'(a_im_p2) - SW'(p_im_p2);
  end

  // Control path: valid bits, butterfly counter and frame markers
  always_ff @(posedge clk) begin
    if (rst) begin
      j         <= '0;
      vld_p1    <= 1'b0;
      last_p1   <= 1'b0;
      vld_p2    <= 1'b0;
      last_p2   <= 1'b0;
      vld_p3    <= 1'b0;
      last_p3   <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (en) begin
      if (accept) j <= j + 1'b1;
      // p1: beat capture
      vld_p1    <= accept;
      last_p1   <= accept & (&j);
      // p2: complex multiply
      vld_p2    <= vld_p1;
      last_p2   <= last_p1;
      // p3: add / subtract / scale
      vld_p3    <= vld_p2;
      last_p3   <= last_p2;
      // output: saturated beat
      out_valid <= vld_p3;
      out_last  <= vld_p3 & last_p3;
    end
  end

  // Data path registers; these carry no reset
  always_ff @(posedge clk) begin
    if (en) begin
      // p1: beat capture
      a_re_p1  <= in_a_re;
      a_im_p1  <= in_a_im;
      b_re_p1  <= in_b_re;
      b_im_p1  <= in_b_im;
      scale_p1 <= scale;
      // p2: complex multiply
      a_re_p2  <= a_re_p1;
      a_im_p2  <= a_im_p1;
      p_re_p2  <= round_prod(mul_re);
      p_im_p2  <= round_prod(mul_im);
      scale_p2 <= scale_p1;
      // p3: add / subtract / scale
      s_re_p3  <= halve(sum_re, scale_p2);
      s_im_p3  <= halve(sum_im, scale_p2);
      d_re_p3  <= halve(dif_re, scale_p2);
      d_im_p3  <= halve(dif_im, scale_p2);
    end
  end

  // Output data: cleared by reset, otherwise loaded with each valid beat
  always_ff @(posedge clk) begin
    if (rst) begin
      out_x0_re <= '0;
      out_x0_im <= '0;
      out_x1_re <= '0;
      out_x1_im <= '0;
    end else if (en && vld_p3) begin
      out_x0_re <= sat(s_re_p3);
      out_x0_im <= sat(s_im_p3);
      out_x1_re <= sat(d_re_p3);
      out_x1_im <= sat(d_im_p3);
    end
  end

  assign ovf_set = en & vld_p3 & (sat_hit(s_re_p3) | sat_hit(s_im_p3) |
                                  sat_hit(d_re_p3) | sat_hit(d_im_p3));

  // Sticky overflow; a new saturation beats a simultaneous clear
  always_ff @(posedge clk) begin
    if (rst)            ovf <= 1'b0;
    else if (ovf_set)   ovf <= 1'b1;
    else if (clear_ovf) ovf <= 1'b0;
  end

endmodule
